mem_port_arbiter: RTL and testbench

- Owns the single main-memory port and shares it between two requesters:
  - the cache refill path, which feeds block_buffer one word at a time;
  - the write-back buffer drain, which produces a byte stream with a valid/ready handshake.
- Sequences a refill as a burst of BLOCK_SIZE word reads.
- Passes write-back bytes through at whole-block granularity.
- Applies fixed refill priority, with a starvation guard for write-back.
- Sits between cache_controller/write_back_buffer and main memory.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_burst_counter.sv | 33 +++
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the main-memory port arbiter:
//   - arb_state_e : arbiter state encoding (IDLE, REFILL, WB)
//   - DEF_BLOCK_SIZE, WORD_IDX_W, BYTES_PER_BLOCK : default block geometry
//     (8 words of 2 bytes each)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WB     = 2'd2
  } arb_state_e;

  localparam int DEF_BLOCK_SIZE  = 8;
  localparam int WORD_IDX_W      = $clog2(DEF_BLOCK_SIZE);
  localparam int BYTES_PER_BLOCK = 2 * DEF_BLOCK_SIZE;

endpackage

// File: rtl/arb_burst_counter.sv
// arb_burst_counter
//   Generic up-counter used to sequence bursts. Counts accepted beats and
//   wraps to zero on the beat that hits the terminal value.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears the count
//   inc   : advance by one this cycle
//   count : current beat index
//   last  : count is at the terminal value (LAST)
module arb_burst_counter
  import mem_arb_pkg::*;
#(
  parameter int W    = WORD_IDX_W,
  parameter int LAST = DEF_BLOCK_SIZE - 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == W'(LAST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Owns the single main-memory port and shares it between the cache refill
//   path (burst of BLOCK_SIZE word reads) and the write-back drain (byte
//   stream, whole-block granularity). Refill has fixed priority; after
//   MAX_REFILL_STREAK consecutive refill blocks granted while write-back was
//   waiting, the next grant goes to write-back.
//
// Ports:
//   clk, reset                 : clock (rising) and async active-low reset
//   refill_req, refill_addr    : refill request level and any byte address in the block
//   refill_word(_valid)        : read word and its one-cycle strobe
//   refill_done                : pulse on the last word of a refill
//   wb_evict_valid/_ready      : write-back byte handshake
//   wb_byte, wb_addr           : write-back byte and its address
//   mem_addr, mem_read_enable, mem_write_enable, mem_wdata : memory request
//   mem_rdata, mem_ready       : memory response / completion
//   busy                       : arbiter is not idle
//
// Build option:
//   MEM_PORT_ARB_STATS_EN adds saturating 16-bit counters
//   stat_refill_blocks, stat_wb_blocks, stat_wait_cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLOCK_SIZE        = DEF_BLOCK_SIZE,
  parameter int WORD_SIZE         = 16,
  parameter int ADDR_SIZE         = 16,
  parameter int MAX_REFILL_STREAK = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 refill_req,
  input  logic [ADDR_SIZE-1:0] refill_addr,
  output logic [WORD_SIZE-1:0] refill_word,
  output logic                 refill_word_valid,
  output logic                 refill_done,
  input  logic                 wb_evict_valid,
  input  logic [7:0]           wb_byte,
  input  logic [ADDR_SIZE-1:0] wb_addr,
  output logic                 wb_evict_ready,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_read_enable,
  output logic                 mem_write_enable,
  output logic [7:0]           mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 busy
`ifdef MEM_PORT_ARB_STATS_EN
  ,
  output logic [15:0]          stat_refill_blocks,
  output logic [15:0]          stat_wb_blocks,
  output logic [15:0]          stat_wait_cycles
`endif
);

  localparam int WIDX_W     = (BLOCK_SIZE == DEF_BLOCK_SIZE) ? WORD_IDX_W : $clog2(BLOCK_SIZE);
  localparam int BPB        = (BLOCK_SIZE == DEF_BLOCK_SIZE) ? BYTES_PER_BLOCK : 2 * BLOCK_SIZE;
  localparam int BYTE_IDX_W = $clog2(BPB);
  localparam int STREAK_W   = $clog2(MAX_REFILL_STREAK + 1);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                streak_at_max;

  logic [WIDX_W-1:0]     word_cnt;
  logic                  word_last;
  logic                  word_inc;
  logic [BYTE_IDX_W-1:0] byte_cnt;
  logic                  byte_last;
  logic                  byte_inc;

  // Word offset bits of refill_addr are replaced by the burst counter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^refill_addr[WIDX_W:0];

  function automatic logic [STREAK_W-1:0] streak_sat_inc(input logic [STREAK_W-1:0] s);
    return (s == STREAK_W'(MAX_REFILL_STREAK)) ? s : s + STREAK_W'(1);
  endfunction

  assign streak_at_max = (streak_q == STREAK_W'(MAX_REFILL_STREAK));
  assign busy          = (state_q != IDLE);

  arb_burst_counter #(
    .W    (WIDX_W),
    .LAST (BLOCK_SIZE - 1)
  ) u_word_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (word_inc),
    .count (word_cnt),
    .last  (word_last)
  );

  arb_burst_counter #(
    .W    (BYTE_IDX_W),
    .LAST (BPB - 1)
  ) u_byte_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (byte_inc),
    .count (byte_cnt),
    .last  (byte_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    streak_d          = streak_q;
    word_inc          = 1'b0;
    byte_inc          = 1'b0;
    mem_addr          = '0;
    mem_read_enable   = 1'b0;
    mem_write_enable  = 1'b0;
    mem_wdata         = '0;
    refill_word       = '0;
    refill_word_valid = 1'b0;
    refill_done       = 1'b0;
    wb_evict_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        // Refill wins unless write-back has been passed over too often.
        if (refill_req && !(wb_evict_valid && streak_at_max)) begin
          state_d = REFILL;
        end else if (wb_evict_valid) begin
          state_d = WB;
        end
      end

      REFILL: begin
        mem_read_enable = 1'b1;
        mem_addr        = {refill_addr[ADDR_SIZE-1:WIDX_W+1], word_cnt, 1'b0};
        if (mem_ready) begin
          refill_word       = mem_rdata;
          refill_word_valid = 1'b1;
          word_inc          = 1'b1;
          if (word_last) begin
            refill_done = 1'b1;
            state_d     = IDLE;
            // Streak only grows while write-back is actually waiting.
            streak_d    = wb_evict_valid ? streak_sat_inc(streak_q) : '0;
          end
        end
      end

      WB: begin
        mem_write_enable = wb_evict_valid;
        mem_addr         = wb_addr;
        mem_wdata        = wb_byte;
        wb_evict_ready   = mem_ready & wb_evict_valid;
        byte_inc         = mem_ready & wb_evict_valid;
        if (byte_inc && byte_last) begin
          state_d  = IDLE;
          streak_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_PORT_ARB_STATS_EN
  function automatic logic [15:0] sat16_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_refill_blocks <= '0;
      stat_wb_blocks     <= '0;
      stat_wait_cycles   <= '0;
    end else begin
      if (refill_done) begin
        stat_refill_blocks <= sat16_inc(stat_refill_blocks);
      end
      if (byte_inc && byte_last) begin
        stat_wb_blocks <= sat16_inc(stat_wb_blocks);
      end
      if ((mem_read_enable || mem_write_enable) && !mem_ready) begin
        stat_wait_cycles <= sat16_inc(stat_wait_cycles);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int BS   = 8;
  localparam int MAXS = 3;

  logic        clk;
  logic        reset;
  logic        refill_req;
  logic [15:0] refill_addr;
  logic [15:0] refill_word;
  logic        refill_word_valid;
  logic        refill_done;
  logic        wb_evict_valid;
  logic [7:0]  wb_byte;
  logic [15:0] wb_addr;
  logic        wb_evict_ready;
  logic [15:0] mem_addr;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [7:0]  mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
`ifdef MEM_PORT_ARB_STATS_EN
  logic [15:0] stat_refill_blocks;
  logic [15:0] stat_wb_blocks;
  logic [15:0] stat_wait_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .refill_req        (refill_req),
    .refill_addr       (refill_addr),
    .refill_word       (refill_word),
    .refill_word_valid (refill_word_valid),
    .refill_done       (refill_done),
    .wb_evict_valid    (wb_evict_valid),
    .wb_byte           (wb_byte),
    .wb_addr           (wb_addr),
    .wb_evict_ready    (wb_evict_ready),
    .mem_addr          (mem_addr),
    .mem_read_enable   (mem_read_enable),
    .mem_write_enable  (mem_write_enable),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ready         (mem_ready),
    .busy              (busy)
`ifdef MEM_PORT_ARB_STATS_EN
    ,
    .stat_refill_blocks(stat_refill_blocks),
    .stat_wb_blocks    (stat_wb_blocks),
    .stat_wait_cycles  (stat_wait_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: tracks which requester owns the port and how far
  // through its block it is, and derives every output from that.
  int m_mode;    // 0 idle, 1 refill, 2 write-back
  int m_words;   // words delivered in the current refill
  int m_bytes;   // bytes accepted in the current write-back block
  int m_streak;  // refill blocks granted while write-back waited

  initial begin : model_cmp
    logic [15:0] e_addr, e_word;
    logic [7:0]  e_wdata;
    logic        e_rd, e_wr, e_wvalid, e_done, e_ready, e_busy;
    m_mode = 0; m_words = 0; m_bytes = 0; m_streak = 0;
    forever begin
      @(negedge clk);
      #2;
      e_addr = '0; e_word = '0; e_wdata = '0;
      e_rd = 0; e_wr = 0; e_wvalid = 0; e_done = 0; e_ready = 0; e_busy = 0;
      if (!reset) begin
        m_mode = 0; m_words = 0; m_bytes = 0; m_streak = 0;
      end else if (m_mode == 1) begin
        e_busy = 1;
        e_rd   = 1;
        e_addr = (refill_addr & ~16'(2 * BS - 1)) + 16'(2 * m_words);
        if (mem_ready) begin
          e_wvalid = 1;
          e_word   = mem_rdata;
          e_done   = (m_words == BS - 1);
        end
      end else if (m_mode == 2) begin
        e_busy  = 1;
        e_wr    = wb_evict_valid;
        e_addr  = wb_addr;
        e_wdata = wb_byte;
        e_ready = mem_ready && wb_evict_valid;
      end
      chk("m_busy",   32'(busy),              32'(e_busy));
      chk("m_rd",     32'(mem_read_enable),   32'(e_rd));
      chk("m_wr",     32'(mem_write_enable),  32'(e_wr));
      chk("m_addr",   32'(mem_addr),          32'(e_addr));
      chk("m_wdata",  32'(mem_wdata),         32'(e_wdata));
      chk("m_rword",  32'(refill_word),       32'(e_word));
      chk("m_rvalid", 32'(refill_word_valid), 32'(e_wvalid));
      chk("m_done",   32'(refill_done),       32'(e_done));
      chk("m_wready", 32'(wb_evict_ready),    32'(e_ready));
      chk("m_excl",   32'(mem_read_enable & mem_write_enable), 32'(0));
      @(posedge clk);
      if (reset) begin
        case (m_mode)
          0: begin
            if (refill_req && !(wb_evict_valid && m_streak == MAXS)) begin
              m_mode = 1; m_words = 0;
            end else if (wb_evict_valid) begin
              m_mode = 2; m_bytes = 0;
            end
          end
          1: if (mem_ready) begin
            m_words++;
            if (m_words == BS) begin
              m_mode   = 0;
              m_words  = 0;
              m_streak = wb_evict_valid ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end
          end
          default: if (mem_ready && wb_evict_valid) begin
            m_bytes++;
            if (m_bytes == 2 * BS) begin
              m_mode   = 0;
              m_bytes  = 0;
              m_streak = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin : watchdog
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted got 1 want 0");
    $fatal(1, "cycle budget exhausted");
  end

  // Directed scenarios with hand-computed expectations, then random traffic.
  initial begin : stim
    int  strobes;
    bit  ref_pending;
    bit  is_wb;
    int  len;
    bit  kinds [8];
    reset = 0; refill_req = 0; refill_addr = '0; wb_evict_valid = 0;
    wb_byte = '0; wb_addr = '0; mem_rdata = '0; mem_ready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rd",   32'(mem_read_enable), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    @(negedge clk); reset = 1;

    // Refill at 0x3A5 with memory always ready
    @(negedge clk);
    refill_req = 1; refill_addr = 16'h03A5; mem_ready = 1;
    #1; chk("t1_grant_lat", 32'(mem_read_enable), 32'(0));
    strobes = 0;
    for (int i = 0; i < BS; i++) begin
      @(negedge clk);
      mem_rdata = 16'hA000 + 16'(i);
      #1;
      chk("t1_addr", 32'(mem_addr), 32'h3A0 + 32'(2 * i));
      chk("t1_word", 32'(refill_word), 32'hA000 + 32'(i));
      chk("t1_done", 32'(refill_done), 32'(i == BS - 1));
      if (refill_word_valid) strobes++;
    end
    chk("t1_strobes", 32'(strobes), 32'(8));
    @(negedge clk); refill_req = 0;
    #1; chk("t1_busy_low", 32'(busy), 32'(0));

    // Refill with ready toggling: ready on odd cycles only
    @(negedge clk);
    refill_req = 1; refill_addr = 16'h1234; mem_ready = 0;
    #1; chk("t2_idle", 32'(busy), 32'(0));
    strobes = 0;
    for (int c = 0; c < 2 * BS; c++) begin
      @(negedge clk);
      mem_ready = c[0];
      mem_rdata = 16'(c);
      #1;
      chk("t2_addr", 32'(mem_addr), 32'h1230 + 32'(2 * (c / 2)));
      chk("t2_valid", 32'(refill_word_valid), 32'(c[0]));
      if (refill_word_valid) begin
        strobes++;
        chk("t2_word", 32'(refill_word), 32'(c));
      end
      chk("t2_done", 32'(refill_done), 32'(c == 2 * BS - 1));
    end
    chk("t2_strobes", 32'(strobes), 32'(8));
    @(negedge clk); refill_req = 0; mem_ready = 1;
    #1; chk("t2_busy_low", 32'(busy), 32'(0));

    // Write-back block at 0x5F0..0x5FF, then a 17th byte
    @(negedge clk);
    wb_evict_valid = 1; wb_addr = 16'h05F0; wb_byte = 8'h00;
    #1; chk("t3_idle_ready", 32'(wb_evict_ready), 32'(0));
    for (int i = 0; i < 2 * BS; i++) begin
      @(negedge clk);
      wb_addr = 16'h05F0 + 16'(i); wb_byte = 8'(i * 3);
      #1;
      chk("t3_ready", 32'(wb_evict_ready), 32'(1));
      chk("t3_addr",  32'(mem_addr), 32'h5F0 + 32'(i));
      chk("t3_wdata", 32'(mem_wdata), 32'(8'(i * 3)));
    end
    @(negedge clk); wb_addr = 16'h0600; wb_byte = 8'hAA;
    #1;
    chk("t3_gap_ready", 32'(wb_evict_ready), 32'(0));
    chk("t3_gap_busy",  32'(busy), 32'(0));
    @(negedge clk);
    #1;
    chk("t3_regrant", 32'(wb_evict_ready), 32'(1));
    @(negedge clk); reset = 0; wb_evict_valid = 0;
    #1; chk("t3_rst_busy", 32'(busy), 32'(0));
    @(negedge clk); reset = 1;

    // Both requesters held: three refills, forced write-back, repeat
    kinds = '{0, 0, 0, 1, 0, 0, 0, 1};
    @(negedge clk);
    refill_req = 1; refill_addr = 16'h2000; wb_evict_valid = 1; wb_addr = 16'h7000; mem_ready = 1;
    #1; chk("t4_idle0", 32'(busy), 32'(0));
    for (int b = 0; b < 8; b++) begin
      is_wb = kinds[b];
      len   = is_wb ? 2 * BS : BS;
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        #1;
        if (is_wb) chk("t4_wb_grant", 32'(wb_evict_ready), 32'(1));
        else       chk("t4_rf_grant", 32'(mem_read_enable), 32'(1));
      end
      @(negedge clk);
      if (b == 7) begin refill_req = 0; wb_evict_valid = 0; end
      #1; chk("t4_gap", 32'(busy), 32'(0));
    end

    // refill_req rises during byte 5 of a write-back block
    @(negedge clk);
    wb_evict_valid = 1; wb_addr = 16'h0100;
    #1; chk("t5_idle", 32'(busy), 32'(0));
    for (int i = 0; i < 2 * BS; i++) begin
      @(negedge clk);
      wb_addr = 16'h0100 + 16'(i);
      if (i == 5) begin refill_req = 1; refill_addr = 16'h0805; end
      #1;
      chk("t5_wb_hold", 32'(mem_write_enable), 32'(1));
      chk("t5_no_read", 32'(mem_read_enable), 32'(0));
    end
    @(negedge clk); wb_evict_valid = 0;
    #1; chk("t5_gap", 32'(busy), 32'(0));
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      mem_rdata = 16'h5500 + 16'(w);
      #1;
      chk("t5_rf_addr", 32'(mem_addr), 32'h800 + 32'(2 * w));
    end

    // Reset at word 4 aborts the burst; the retry starts at word 0
    @(negedge clk); reset = 0;
    #1;
    chk("t6_rd",    32'(mem_read_enable), 32'(0));
    chk("t6_addr",  32'(mem_addr), 32'(0));
    chk("t6_valid", 32'(refill_word_valid), 32'(0));
    chk("t6_busy",  32'(busy), 32'(0));
    @(negedge clk);
    #1; chk("t6_no_done", 32'(refill_done), 32'(0));
    @(negedge clk); reset = 1;
    #1; chk("t6_idle", 32'(busy), 32'(0));
    for (int w = 0; w < BS; w++) begin
      @(negedge clk);
      #1;
      chk("t6_addr_re", 32'(mem_addr), 32'h800 + 32'(2 * w));
      chk("t6_done_re", 32'(refill_done), 32'(w == BS - 1));
    end
    @(negedge clk); refill_req = 0;
    #1; chk("t6_end", 32'(busy), 32'(0));

    // Random traffic against the model
    ref_pending = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) begin
        reset = 0; ref_pending = 0;
      end else begin
        reset = 1;
      end
      if (reset && !ref_pending && $urandom_range(0, 3) == 0) begin
        ref_pending = 1;
        refill_addr = 16'($urandom);
      end
      refill_req     = ref_pending;
      wb_evict_valid = ($urandom_range(0, 2) != 0);
      wb_addr        = 16'($urandom);
      wb_byte        = 8'($urandom);
      mem_ready      = ($urandom_range(0, 3) != 0);
      mem_rdata      = 16'($urandom);
      #1;
      if (refill_done) ref_pending = 0;
    end

    @(negedge clk);
    reset = 0; refill_req = 0; wb_evict_valid = 0; mem_ready = 0;
    repeat (2) @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
